sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 53 +++++
 rtl/sync_fifo.sv | 116 +++++++++++
 tb/tb_sync_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock byte FIFO.
// The optional sticky error flags are enabled with SYNC_FIFO_ERR_FLAGS_EN.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    function automatic int fifo_depth(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port and one registered read port that
// holds its value when no read is accepted. Contents survive reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Next read-port value: load the addressed word on a pop, otherwise hold
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Storage array; writes are suppressed while reset is asserted
    always_ff @(posedge clock) begin
        if (resetn && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read data, cleared by reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered output, occupancy count and flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_accept;
    logic                  wr_accept;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;

    // A pop frees a slot this cycle, so a push into a full FIFO is legal alongside it
    assign rd_accept = read_enable && !empty;
    assign wr_accept = write_enable && (!full || rd_accept);

    // Pointer and occupancy next-state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_accept) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_accept) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wptr_q  <= {ADDR_WIDTH{1'b0}};
            rptr_q  <= {ADDR_WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_accept),
        .wr_addr (wptr_q),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rptr_q),
        .rd_data (data_out)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set on a dropped push or a pop of an empty FIFO
    always_comb begin
        overflow_d  = overflow_q | (write_enable & full & ~read_enable);
        underflow_d = underflow_q | (read_enable & empty);
    end

    // Error flag registers, cleared only by reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table plus a randomized
// run against a queue model.
module tb_sync_fifo;

    logic       clock;
    logic       resetn;
    logic       write_enable;
    logic [7:0] data_in;
    logic       read_enable;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo dut (
        .clock        (clock),
        .resetn       (resetn),
        .write_enable (write_enable),
        .data_in      (data_in),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ovf/unf hold the values expected when the error flags are built
    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] din;
        logic       re;
        logic [7:0] dout;
        logic [4:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic we, input logic [7:0] din,
                                input logic re, input logic [7:0] dout, input logic [4:0] cnt,
                                input logic ovf, input logic unf);
        vec_t v;
        v.rst = rst; v.we = we; v.din = din; v.re = re;
        v.dout = dout; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic we, input logic [7:0] din, input logic re);
        resetn       = ~rst;
        write_enable = we;
        data_in      = din;
        read_enable  = re;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] model_q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;

    initial begin
        resetn       = 1'b0;
        write_enable = 1'b0;
        data_in      = 8'h00;
        read_enable  = 1'b0;

        // 1: reset, idle, read while empty
        add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        // 2: three writes then three reads
        add(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 5'd0, 1'b0, 1'b0);
        // 3: fill, dropped 17th write, drain
        for (int i = 0; i < 16; i++) add(1'b0, 1'b1, 8'(i), 1'b0, 8'h33, 5'(i + 1), 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hAA, 1'b0, 8'h33, 5'd16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 5'(15 - i), 1'b1, 1'b0);
        // 4: fill, simultaneous read+write while full, drain
        add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) add(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 5'(i + 1), 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h55, 1'b1, 8'h00, 5'd16, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 5'(16 - i), 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 5'd0, 1'b0, 1'b0);
        // 5: simultaneous read+write while empty: no fall-through
        add(1'b0, 1'b1, 8'h77, 1'b1, 8'h55, 5'd1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 5'd0, 1'b0, 1'b1);
        // 6: reset mid-operation (with concurrent read+write) discards contents
        add(1'b0, 1'b1, 8'hA0, 1'b0, 8'h77, 5'd1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'hA1, 1'b0, 8'h77, 5'd2, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'hA2, 1'b0, 8'h77, 5'd3, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'hA3, 1'b0, 8'h77, 5'd4, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'hA4, 1'b0, 8'h77, 5'd5, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'hEE, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].we, vecs[i].din, vecs[i].re);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            exp_ovf = vecs[i].ovf;
            exp_unf = vecs[i].unf;
`else
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
`endif
            chk("data_out",  i, 32'(data_out),  32'(vecs[i].dout));
            chk("count",     i, 32'(count),     32'(vecs[i].cnt));
            chk("full",      i, 32'(full),      32'(vecs[i].cnt == 5'd16));
            chk("empty",     i, 32'(empty),     32'(vecs[i].cnt == 5'd0));
            chk("overflow",  i, 32'(overflow),  32'(exp_ovf));
            chk("underflow", i, 32'(underflow), 32'(exp_unf));
        end

        // Randomized traffic against a queue model, biased to reach full then empty
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        model_q.delete();
        exp_dout = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            int  thr_w;
            int  thr_r;
            logic we;
            logic re;
            logic [7:0] din;
            logic rd_acc;
            logic wr_acc;
            thr_w  = ((i / 500) % 2 == 0) ? 75 : 30;
            thr_r  = ((i / 500) % 2 == 0) ? 30 : 75;
            we     = ($urandom_range(0, 99) < thr_w);
            re     = ($urandom_range(0, 99) < thr_r);
            din    = 8'($urandom_range(0, 255));
            rd_acc = re && (model_q.size() > 0);
            wr_acc = we && ((model_q.size() < 16) || rd_acc);
            if (rd_acc) exp_dout = model_q.pop_front();
            if (wr_acc) model_q.push_back(din);
            apply(1'b0, we, din, re);
            chk("rand_data_out", i, 32'(data_out), 32'(exp_dout));
            chk("rand_count",    i, 32'(count),    32'(model_q.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
